clq_arbiter: RTL and testbench
==============================

Name: clq_arbiter

Overview:
- Sequences all writes into the clause queue (CLQ).
- Arbitrates between the clause loader and N_ENG BCP engines that return clauses.
- Loader has priority. Engines are served round-robin, with a starvation guard so engines are not locked out.
- Tracks CLQ free slots with a credit counter and issues one registered push per cycle at most.

Parameters:
- N_ENG, 4: number of engine requesters (2..8).
- CLA_W, 96: width of one packed clause.
- CLQ_DEPTH, 16: CLQ capacity; initial credit count.
- MAX_STARVE, 8: consecutive loader grants allowed while any engine is waiting.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  loader has a clause
- ld_cla  in  CLA_W  loader clause
- ld_ready  out  1  loader clause accepted this cycle
- eng_valid  in  N_ENG  per-engine request
- eng_cla  in  N_ENG*CLA_W  engine clauses; engine i occupies bits [i*CLA_W +: CLA_W]
- eng_ready  out  N_ENG  per-engine accept (one-hot or zero)
- clq_push  out  1  registered push strobe to CLQ
- clq_data  out  CLA_W  registered clause to CLQ
- clq_pop  in  1  CLQ consumer popped an entry (returns one credit)
- credits  out  $clog2(CLQ_DEPTH+1)  current free slots
- err_overflow  out  1  sticky: pop received while credits == CLQ_DEPTH

Behaviour:
- Reset values:
  - clq_push=0, clq_data=0, credits=CLQ_DEPTH.
  - rr_ptr=0, starve_cnt=0, err_overflow=0.
  - ld_ready=0, eng_ready=0.
  - Reset mid-operation discards the in-flight registered push and restores full credits.
- Handshake:
  - valid/ready. A requester holds valid and data stable until it sees ready.
  - ready is combinational from this cycle's inputs and state; the transfer occurs on the clock edge where valid && ready.
- Grant enable:
  - can_grant = (credits != 0) || clq_pop.
  - When can_grant is 0, all ready signals are 0.
- Grant selection, evaluated in this order when can_grant is 1:
  - If starve_cnt == MAX_STARVE and any eng_valid: grant the round-robin engine.
  - Else if ld_valid: grant the loader.
  - Else if any eng_valid: grant the round-robin engine.
  - Else: no grant.
- Round robin:
  - Search eng_valid starting at index rr_ptr, wrapping modulo N_ENG; the first set bit wins.
  - After an engine i grant, rr_ptr <= (i+1) mod N_ENG, wrapping N_ENG-1 to 0.
  - rr_ptr is unchanged on a loader grant or an idle cycle.
- Starvation counter:
  - Loader grant while any eng_valid: starve_cnt += 1, saturating at MAX_STARVE.
  - Engine grant, or no eng_valid: starve_cnt <= 0.
- Output stage (latency 1):
  - clq_push <= grant_any; clq_data <= granted clause.
  - When there is no grant, clq_data holds its previous value.
- Credits:
  - Next credits = credits - grant_any + (clq_pop && !overflow_case).
  - Push and pop in the same cycle: no change.
  - Credits never underflow, because a grant requires credits != 0 or a same-cycle pop.
- Overflow:
  - clq_pop with credits == CLQ_DEPTH and no grant is ignored and sets err_overflow.
  - err_overflow clears only on reset.
- Invariant: at most one grant per cycle; ld_ready and eng_ready are never both active.

Test Plan:
- Reset, then ld_valid=1 continuously, no pops, CLQ_DEPTH=16:
  - exactly 16 pushes;
  - credits goes 16 to 0;
  - ld_ready=0 from the 17th cycle;
  - clq_push lags ld_ready by exactly 1 cycle, with matching data.
- eng_valid=4'b1111 held, ld_valid=0, pops every cycle:
  - grants rotate 0,1,2,3,0;
  - credits stays at 16;
  - eng_ready is one-hot each cycle.
- ld_valid=1 and eng_valid=4'b0100 held, MAX_STARVE=8:
  - 8 loader grants, then engine 2 granted on the 9th cycle;
  - starve_cnt returns to 0;
  - the loader is granted on the 10th cycle.
- credits=0, clq_pop=1, ld_valid=1 in the same cycle:
  - loader granted;
  - credits stays 0;
  - push seen next cycle.
- credits=16, clq_pop=1 with no requests:
  - err_overflow=1 and stays 1;
  - credits remain 16.
- Assert reset during back-to-back engine grants with rr_ptr=2:
  - next cycle clq_push=0, credits=16, rr_ptr=0;
  - after release, the first grant goes to the lowest valid engine index.

Source files
------------

// File: rtl/clq_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clq_arbiter: loader/engine arbiter feeding the clause queue under credit control.
// Rev 1.0
// ----------------------------------------------------------------------------
module clq_arbiter #(
  parameter int N_ENG      = 4,
  parameter int CLA_W      = 96,
  parameter int CLQ_DEPTH  = 16,
  parameter int MAX_STARVE = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ld_valid,
  input  logic [CLA_W-1:0]                   ld_cla,
  output logic                               ld_ready,
  input  logic [N_ENG-1:0]                   eng_valid,
  input  logic [N_ENG*CLA_W-1:0]             eng_cla,
  output logic [N_ENG-1:0]                   eng_ready,
  output logic                               clq_push,
  output logic [CLA_W-1:0]                   clq_data,
  input  logic                               clq_pop,
  output logic [$clog2(CLQ_DEPTH+1)-1:0]     credits,
  output logic                               err_overflow
);

  localparam int c_ptr_w = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam int c_ext_w = c_ptr_w + 1;
  localparam int c_cred_w = $clog2(CLQ_DEPTH + 1);
  localparam int c_stv_w = $clog2(MAX_STARVE + 1);

  localparam logic [c_ext_w-1:0]  c_n_ext     = c_ext_w'(N_ENG);
  localparam logic [c_ptr_w-1:0]  c_last      = c_ptr_w'(N_ENG - 1);
  localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cred_w-1:0] c_depth     = c_cred_w'(CLQ_DEPTH);
  localparam logic [c_stv_w-1:0]  c_stv_max   = c_stv_w'(MAX_STARVE);
  localparam logic [c_stv_w-1:0]  c_stv_one   = c_stv_w'(1);

  logic [c_ptr_w-1:0]  r_rr_ptr;
  logic [c_stv_w-1:0]  r_starve;
  logic [c_cred_w-1:0] r_credits;
  logic                r_push;
  logic [CLA_W-1:0]    r_data;
  logic                r_err;

  logic                w_can_grant;
  logic                w_any_eng;
  logic                w_starve_full;
  logic                w_rr_hit;
  logic [c_ptr_w-1:0]  w_rr_idx;
  logic [c_ext_w-1:0]  w_ext;
  logic                w_grant_ld;
  logic                w_grant_eng;
  logic                w_grant_any;
  logic                w_ovf;
  logic [CLA_W-1:0]    w_eng_data;
  logic [CLA_W-1:0]    w_grant_data;
  logic [c_cred_w-1:0] w_credits_nxt;

  // Walk from the highest offset down so the first valid bit at/after r_rr_ptr wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_ext    = '0;
    for (int k = N_ENG - 1; k >= 0; k--) begin
      w_ext = {1'b0, r_rr_ptr} + c_ext_w'(k);
      if (w_ext >= c_n_ext) begin
        w_ext = w_ext - c_n_ext;
      end
      if (eng_valid[w_ext[c_ptr_w-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_ext[c_ptr_w-1:0];
      end
    end
  end

  always_comb begin
    w_eng_data = '0;
    for (int k = 0; k < N_ENG; k++) begin
      if (w_rr_idx == c_ptr_w'(k)) begin
        w_eng_data = eng_cla[k*CLA_W +: CLA_W];
      end
    end
  end

  assign w_any_eng     = |eng_valid;
  assign w_starve_full = (r_starve == c_stv_max);
  assign w_can_grant   = !reset && ((r_credits != '0) || clq_pop);
  assign w_grant_eng   = w_can_grant && w_rr_hit && (w_starve_full || !ld_valid);
  assign w_grant_ld    = w_can_grant && ld_valid && !(w_starve_full && w_any_eng);
  assign w_grant_any   = w_grant_ld || w_grant_eng;
  assign w_grant_data  = w_grant_ld ? ld_cla : w_eng_data;

  // A pop against a full credit pool has nothing to return; it is dropped and flagged.
  assign w_ovf         = clq_pop && (r_credits == c_depth) && !w_grant_any;
  assign w_credits_nxt = r_credits - c_cred_w'(w_grant_any) + c_cred_w'(clq_pop && !w_ovf);

  always_comb begin
    eng_ready = '0;
    if (w_grant_eng) begin
      eng_ready[w_rr_idx] = 1'b1;
    end
  end

  assign ld_ready = w_grant_ld;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr  <= '0;
      r_starve  <= '0;
      r_credits <= c_depth;
      r_push    <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_push    <= w_grant_any;
      r_credits <= w_credits_nxt;
      if (w_grant_any) begin
        r_data <= w_grant_data;
      end
      if (w_grant_eng) begin
        r_rr_ptr <= (w_rr_idx == c_last) ? '0 : w_rr_idx + c_ptr_one;
      end
      if (w_grant_ld && w_any_eng) begin
        if (!w_starve_full) begin
          r_starve <= r_starve + c_stv_one;
        end
      end else if (w_grant_eng || !w_any_eng) begin
        r_starve <= '0;
      end
      if (w_ovf) begin
        r_err <= 1'b1;
      end
    end
  end

  assign clq_push     = r_push;
  assign clq_data     = r_data;
  assign credits      = r_credits;
  assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clq_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_clq_arbiter: directed scoreboard bench for clq_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_clq_arbiter;
  localparam int N_ENG      = 4;
  localparam int CLA_W      = 96;
  localparam int CLQ_DEPTH  = 16;
  localparam int MAX_STARVE = 8;
  localparam int CW         = $clog2(CLQ_DEPTH + 1);

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   ld_valid;
  logic [CLA_W-1:0]       ld_cla;
  logic                   ld_ready;
  logic [N_ENG-1:0]       eng_valid;
  logic [N_ENG*CLA_W-1:0] eng_cla;
  logic [N_ENG-1:0]       eng_ready;
  logic                   clq_push;
  logic [CLA_W-1:0]       clq_data;
  logic                   clq_pop;
  logic [CW-1:0]          credits;
  logic                   err_overflow;

  typedef struct {
    logic [CLA_W-1:0] data;
    int               stamp;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pushes = 0;
  int   ld_n   = 0;

  clq_arbiter #(
    .N_ENG(N_ENG), .CLA_W(CLA_W), .CLQ_DEPTH(CLQ_DEPTH), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_cla(ld_cla), .ld_ready(ld_ready),
    .eng_valid(eng_valid), .eng_cla(eng_cla), .eng_ready(eng_ready),
    .clq_push(clq_push), .clq_data(clq_data), .clq_pop(clq_pop),
    .credits(credits), .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [CLA_W-1:0] ld_word(input int n);
    return {32'hA5A5_0000 + 32'(n), 64'h0123_4567_89AB_CDEF ^ 64'(n)};
  endfunction

  function automatic logic [CLA_W-1:0] eng_word(input int i);
    return {32'hE000_0000 + 32'(i), 64'hFEDC_BA98_7654_3210 + 64'(i)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every push must match the oldest expectation, exactly one cycle after its grant.
  always @(negedge clock) begin
    if (clq_push) begin
      pushes++;
      if (sb.size() == 0) begin
        chk("unexpected_push", clq_push, 1'b0);
      end else begin
        e_mon = sb.pop_front();
        chk("push_data", clq_data, e_mon.data);
        chk("push_latency", cyc, e_mon.stamp + 1);
      end
    end else if (sb.size() != 0 && sb[0].stamp + 1 <= cyc) begin
      e_mon = sb.pop_front();
      chk("missing_push", clq_push, 1'b1);
    end
  end

  // One cycle: drive at posedge+1, check readies/credits at negedge, record expected push.
  task automatic step(input logic lv, input logic [N_ENG-1:0] ev, input logic pop,
                      input logic exp_ld, input logic [N_ENG-1:0] exp_eng,
                      input int exp_cred, input string tag);
    logic adv;
    int   idx;
    exp_t e;
    ld_valid  = lv;
    eng_valid = ev;
    clq_pop   = pop;
    @(negedge clock);
    chk({tag, "_ld_ready"}, ld_ready, exp_ld);
    chk({tag, "_eng_ready"}, eng_ready, exp_eng);
    if (exp_cred >= 0) chk({tag, "_credits"}, credits, exp_cred);
    idx = 0;
    for (int k = 0; k < N_ENG; k++) if (exp_eng[k]) idx = k;
    if (exp_ld) begin
      e.data = ld_cla; e.stamp = cyc; sb.push_back(e);
    end else if (exp_eng != '0) begin
      e.data = eng_word(idx); e.stamp = cyc; sb.push_back(e);
    end
    adv = ld_ready;
    @(posedge clock);
    #1;
    if (adv) begin
      ld_n++;
      ld_cla = ld_word(ld_n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    ld_valid  = 1'b0;
    eng_valid = '0;
    clq_pop   = 1'b0;
    ld_cla    = ld_word(0);
    for (int i = 0; i < N_ENG; i++) eng_cla[i*CLA_W +: CLA_W] = eng_word(i);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    chk("rst_push", clq_push, 1'b0);
    chk("rst_data", clq_data, '0);
    chk("rst_credits", credits, CLQ_DEPTH);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_eng_ready", eng_ready, '0);
    @(posedge clock); #1;

    // Loader fills the CLQ with no pops: 16 grants, then stalled on credits.
    pushes = 0;
    for (int c = 0; c < 18; c++)
      step(1'b1, '0, 1'b0, c < 16, '0, (c <= 16) ? 16 - c : 0, "t1");
    chk("t1_push_count", pushes, 16);

    // Zero credits but a same-cycle pop still lets the loader through.
    step(1'b1, '0, 1'b1, 1'b1, '0, 0, "t4a");
    step(1'b0, '0, 1'b0, 1'b0, '0, 0, "t4b");
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, '0, i, "drain");
    step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t4c");
    chk("t4_err", err_overflow, 1'b0);

    // All engines requesting, pops every cycle: rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'hF, 1'b1, 1'b0, 4'b0001 << (i % 4), 16, "t2");
    step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t2_idle");

    // Starvation guard: 8 loader grants, engine 2 on the 9th, loader again on the 10th.
    for (int i = 1; i <= 10; i++)
      step(1'b1, 4'b0100, 1'b0, i != 9, (i == 9) ? 4'b0100 : 4'b0000, 17 - i, "t3");
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 6 + i, "refill");
    step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t3_full");
    chk("t3_sb_empty", sb.size(), 0);

    // Pop against full credits: ignored and flagged stickily.
    chk("t5_err_before", err_overflow, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 16, "t5a");
    step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t5b");
    chk("t5_err_set", err_overflow, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t5c");
    chk("t5_err_sticky", err_overflow, 1'b1);

    // rr_ptr is 3 here: grants 3,0,1 leave it at 2, then reset mid-stream.
    step(1'b0, 4'hF, 1'b1, 1'b0, 4'b1000, 16, "t6a");
    step(1'b0, 4'hF, 1'b1, 1'b0, 4'b0001, 16, "t6b");
    step(1'b0, 4'hF, 1'b1, 1'b0, 4'b0010, 16, "t6c");
    reset = 1'b1;
    step(1'b0, 4'hF, 1'b1, 1'b0, 4'b0000, 16, "t6_rst");
    reset = 1'b0;
    chk("t6_push_after_rst", clq_push, 1'b0);
    chk("t6_err_cleared", err_overflow, 1'b0);
    step(1'b0, 4'b0110, 1'b1, 1'b0, 4'b0010, 16, "t6_post");
    step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t6_idle");
    step(1'b0, '0, 1'b0, 1'b0, '0, 16, "t6_end");
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
